// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between two byte requesters
module uart_tx_arbiter #(
    parameter int          DATA_W      = 8,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [1:0]  RST_BAUD    = 2'b11,
    parameter logic [1:0]  RST_PARITY  = 2'b01
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_baud_rate,
    input  logic [1:0]        cfg_parity_type,
    input  logic              err_clr,
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_data,
    output logic [1:0]        tx_baud_rate,
    output logic [1:0]        tx_parity_type,
    input  logic              tx_active_flag,
    input  logic              tx_done_flag,
    output logic              busy,
    output logic              grant,
    output logic              cfg_pending,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACT, WAIT_DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [1:0]    pend_baud, pend_parity;
    logic          win, accept, waiting, tmo;

    // The opposite of the last grant wins a tie; a sole requester always wins.
    // Readies are held off in the cycle that a pending config is applied.
    assign win        = (req0_valid && req1_valid) ? !grant : req1_valid;
    assign req0_ready = (state == IDLE) && !cfg_pending && req0_valid && !win;
    assign req1_ready = (state == IDLE) && !cfg_pending && req1_valid && win;
    assign accept     = req0_ready || req1_ready;
    assign waiting    = (state == WAIT_ACT) || (state == WAIT_DONE);
    assign tmo        = waiting && (cnt == CNT_LAST) && !tx_done_flag;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state: done beats active and timeout while waiting on the transmitter
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = accept ? SEND : IDLE;
            SEND:      next_state = WAIT_ACT;
            WAIT_ACT:  next_state = (tx_done_flag || tmo) ? IDLE : tx_active_flag ? WAIT_DONE : WAIT_ACT;
            WAIT_DONE: next_state = (tx_done_flag || tmo) ? IDLE : WAIT_DONE;
            default:   next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        tx_send = (state == SEND);
        busy    = (state != IDLE);
    end

    // Accepted byte, grant history and the saturating frame timer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_data <= '0;
            grant   <= 1'b1;
            cnt     <= '0;
        end else begin
            if (accept) begin
                tx_data <= win ? req1_data : req0_data;
                grant   <= win;
            end
            if (state == SEND) cnt <= '0;
            else if (waiting)  cnt <= cnt + CW'(cnt != CNT_MAX);
        end
    end

    // Config staging: writes land in pending regs and only reach the transmitter from IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_baud      <= RST_BAUD;
            pend_parity    <= RST_PARITY;
            cfg_pending    <= 1'b0;
            tx_baud_rate   <= RST_BAUD;
            tx_parity_type <= RST_PARITY;
        end else begin
            if (state == IDLE && cfg_pending) begin
                tx_baud_rate   <= pend_baud;
                tx_parity_type <= pend_parity;
            end
            if (cfg_wr) begin
                pend_baud   <= cfg_baud_rate;
                pend_parity <= cfg_parity_type;
            end
            cfg_pending <= cfg_wr ? 1'b1 : (state == IDLE) ? 1'b0 : cfg_pending;
        end
    end

    // Sticky timeout flag; a new timeout outranks a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) timeout_err <= 1'b0;
        else          timeout_err <= tmo ? 1'b1 : err_clr ? 1'b0 : timeout_err;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, framing, config staging and timeout
module tb_uart_tx_arbiter;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_baud_rate = '0, cfg_parity_type = '0;
    logic       err_clr = 1'b0;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [1:0] tx_baud_rate, tx_parity_type;
    logic       tx_active_flag = 1'b0, tx_done_flag = 1'b0;
    logic       busy, grant, cfg_pending, timeout_err;
    int         vectors = 0;
    int         miscompares = 0;

    uart_tx_arbiter #(.DATA_W(8), .TIMEOUT_CYC(16), .RST_BAUD(2'b11), .RST_PARITY(2'b01)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .cfg_wr(cfg_wr), .cfg_baud_rate(cfg_baud_rate), .cfg_parity_type(cfg_parity_type),
        .err_clr(err_clr), .tx_send(tx_send), .tx_data(tx_data),
        .tx_baud_rate(tx_baud_rate), .tx_parity_type(tx_parity_type),
        .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
        .busy(busy), .grant(grant), .cfg_pending(cfg_pending), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_send"}, tx_send, 0);
        check({tag, "_data"}, tx_data, 0);
        check({tag, "_grant"}, grant, 1);
        check({tag, "_baud"}, tx_baud_rate, 2'b11);
        check({tag, "_par"}, tx_parity_type, 2'b01);
        check({tag, "_pend"}, cfg_pending, 0);
        check({tag, "_err"}, timeout_err, 0);
        check({tag, "_rdy"}, {req0_ready, req1_ready}, 0);
    endtask

    // Entered at the negedge where SEND is visible; transmitter reports active then done
    task automatic run_frame(input logic [7:0] d, input logic g);
        check("send_hi", tx_send, 1);
        check("send_data", tx_data, d);
        check("send_grant", grant, g);
        check("rdy_busy", {req0_ready, req1_ready}, 0);
        @(negedge clock);
        check("send_1cyc", tx_send, 0);
        tx_active_flag = 1'b1;
        @(negedge clock);
        check("wd_busy", busy, 1);
        check("wd_data", tx_data, d);
        tx_active_flag = 1'b0;
        tx_done_flag = 1'b1;
        @(negedge clock);
        tx_done_flag = 1'b0;
        check("frame_idle", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_values("por");
        reset_n = 1'b1;
        // first tie after reset goes to req0
        @(negedge clock);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        #1 check("tie_rdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_frame(8'h11, 1'b0);
        // single byte from req1
        req1_valid = 1'b1; req1_data = 8'hA5;
        #1 check("single_rdy", {req0_ready, req1_ready}, 2'b01);
        @(negedge clock);
        req1_valid = 1'b0;
        run_frame(8'hA5, 1'b1);
        // round-robin with both valid continuously
        req0_valid = 1'b1; req0_data = 8'h6D;
        req1_valid = 1'b1; req1_data = 8'hB4;
        #1 check("rr0_rdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clock);
        run_frame(8'h6D, 1'b0);
        req0_data = 8'hAA;
        #1 check("rr1_rdy", {req0_ready, req1_ready}, 2'b01);
        @(negedge clock);
        run_frame(8'hB4, 1'b1);
        req1_data = 8'hC8;
        #1 check("rr2_rdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clock);
        run_frame(8'hAA, 1'b0);
        #1 check("rr3_rdy", {req0_ready, req1_ready}, 2'b01);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_frame(8'hC8, 1'b1);
        // config written mid-frame is held until IDLE
        req0_valid = 1'b1; req0_data = 8'h5A;
        @(negedge clock);
        req0_valid = 1'b0;
        check("cfg_send", tx_send, 1);
        @(negedge clock);
        tx_active_flag = 1'b1;
        @(negedge clock);
        tx_active_flag = 1'b0;
        cfg_wr = 1'b1; cfg_baud_rate = 2'b10; cfg_parity_type = 2'b10;
        @(negedge clock);
        cfg_wr = 1'b0;
        check("cfg_pend", cfg_pending, 1);
        check("cfg_hold_baud", tx_baud_rate, 2'b11);
        check("cfg_hold_par", tx_parity_type, 2'b01);
        tx_done_flag = 1'b1;
        @(negedge clock);
        tx_done_flag = 1'b0;
        check("cfg_idle_baud", tx_baud_rate, 2'b11);
        req1_valid = 1'b1; req1_data = 8'h77;
        #1 check("cfg_apply_rdy", {req0_ready, req1_ready}, 0);
        @(negedge clock);
        check("cfg_new_baud", tx_baud_rate, 2'b10);
        check("cfg_new_par", tx_parity_type, 2'b10);
        check("cfg_cleared", cfg_pending, 0);
        check("cfg_not_busy", busy, 0);
        #1 check("cfg_after_rdy", {req0_ready, req1_ready}, 2'b01);
        @(negedge clock);
        req1_valid = 1'b0;
        run_frame(8'h77, 1'b1);
        check("cfg_kept_baud", tx_baud_rate, 2'b10);
        // timeout: IDLE 15 cycles after entering WAIT_ACT
        req0_valid = 1'b1; req0_data = 8'h99;
        @(negedge clock);
        req0_valid = 1'b0;
        @(negedge clock);
        tx_active_flag = 1'b1;
        @(negedge clock);
        tx_active_flag = 1'b0;
        for (int k = 2; k <= 14; k++) @(negedge clock);
        check("tmo_busy14", busy, 1);
        check("tmo_err14", timeout_err, 0);
        @(negedge clock);
        check("tmo_busy15", busy, 0);
        check("tmo_err15", timeout_err, 1);
        repeat (3) @(negedge clock);
        check("tmo_sticky", timeout_err, 1);
        // second timeout with err_clr in the same cycle
        req1_valid = 1'b1; req1_data = 8'h98;
        @(negedge clock);
        req1_valid = 1'b0;
        @(negedge clock);
        for (int k = 1; k <= 14; k++) @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        check("tmo2_idle", busy, 0);
        check("tmo_set_wins", timeout_err, 1);
        @(negedge clock);
        err_clr = 1'b0;
        check("err_cleared", timeout_err, 0);
        // short frame: done without active
        req0_valid = 1'b1; req0_data = 8'h42;
        @(negedge clock);
        req0_valid = 1'b0;
        check("short_data", tx_data, 8'h42);
        @(negedge clock);
        tx_done_flag = 1'b1;
        @(negedge clock);
        tx_done_flag = 1'b0;
        check("short_idle", busy, 0);
        check("short_no_err", timeout_err, 0);
        // reset in the middle of WAIT_DONE
        req1_valid = 1'b1; req1_data = 8'hE7;
        @(negedge clock);
        req1_valid = 1'b0;
        @(negedge clock);
        tx_active_flag = 1'b1;
        cfg_wr = 1'b1; cfg_baud_rate = 2'b00; cfg_parity_type = 2'b00;
        @(negedge clock);
        tx_active_flag = 1'b0;
        cfg_wr = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_pend", cfg_pending, 1);
        reset_n = 1'b0;
        #1 check_reset_values("mid");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        #1 check("tie2_rdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_frame(8'h11, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
